// File: rtl/wb_cmd_master_if.sv
// Command/response and Wishbone signal bundle for wb_cmd_master.
// master: the bus-master block; slave: its command source, consumer and Wishbone slave.
interface wb_cmd_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i,
        input  cmd_dat_i, cmd_sel_i, rsp_ready_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cmd_ready_o, rsp_valid_o,
        output rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i,
        output cmd_dat_i, cmd_sel_i, rsp_ready_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cmd_ready_o, rsp_valid_o,
        input  rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master driven by a valid/ready command port.
// Ports: wb_clk_i, wb_rst_n_i (async, active low), bus (wb_cmd_master_if.master).
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_n_i,
    wb_cmd_master_if.master bus
);
    localparam int unsigned LOGW = $clog2(TIMEOUT + 1);
    localparam int unsigned TCW  = (LOGW > 8) ? LOGW : 8;
    localparam logic [TCW-1:0] TLAST =
        (TIMEOUT == 0) ? '0 : TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state_q;
    logic [TCW-1:0]  timer_q;
    logic            rdy_q;
    logic            cyc_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [31:0]     adr_q;
    logic [31:0]     dat_q;
    logic            rvld_q;
    logic [31:0]     rdat_q;
    logic            rerr_q;
    logic            to_hit;

    // TIMEOUT of zero never expires; the timer just free-runs.
    assign to_hit = (TIMEOUT != 0) && (timer_q == TLAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            rdy_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rvld_q  <= 1'b0;
            rdat_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rdy_q && bus.cmd_valid_i) begin
                        we_q    <= bus.cmd_we_i;
                        adr_q   <= bus.cmd_adr_i;
                        dat_q   <= bus.cmd_dat_i;
                        sel_q   <= bus.cmd_sel_i;
                        timer_q <= '0;
                        cyc_q   <= 1'b1;
                        rdy_q   <= 1'b0;
                        state_q <= BUS;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                BUS: begin
                    // Error beats ack when both arrive together.
                    if (bus.wbm_err_i) begin
                        cyc_q   <= 1'b0;
                        rvld_q  <= 1'b1;
                        rerr_q  <= 1'b1;
                        rdat_q  <= '0;
                        state_q <= RESP;
                    end else if (bus.wbm_ack_i) begin
                        cyc_q   <= 1'b0;
                        rvld_q  <= 1'b1;
                        rerr_q  <= 1'b0;
                        rdat_q  <= we_q ? '0 : bus.wbm_dat_i;
                        state_q <= RESP;
                    end else if (to_hit) begin
                        cyc_q   <= 1'b0;
                        rvld_q  <= 1'b1;
                        rerr_q  <= 1'b1;
                        rdat_q  <= '1;
                        state_q <= RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rvld_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = rdy_q;
    assign bus.rsp_valid_o = rvld_q;
    assign bus.rsp_dat_o   = rdat_q;
    assign bus.rsp_err_o   = rerr_q;
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = cyc_q;
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;
endmodule
